// File: rtl/model_trainer_lstm_loader.sv
// Streams host words into the LSTM trainer's W/K/U/B/X/R/H buffers, one phase at a time,
// then starts the trainer and waits for it to finish.
module model_trainer_lstm_loader #(
    parameter int unsigned DATA_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 BUSY,
    input  logic [DATA_SIZE-1:0] SIZE_X_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    input  logic [DATA_SIZE-1:0] SIZE_L_IN,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    input  logic                 DATA_IN_VALID,
    output logic                 DATA_IN_READY,
    output logic [DATA_SIZE-1:0] TRAINER_DATA,
    output logic                 TRAINER_W_ENABLE,
    output logic                 TRAINER_K_ENABLE,
    output logic                 TRAINER_U_ENABLE,
    output logic                 TRAINER_B_ENABLE,
    output logic                 TRAINER_X_ENABLE,
    output logic                 TRAINER_R_ENABLE,
    output logic                 TRAINER_H_ENABLE,
    output logic                 TRAINER_START,
    input  logic                 TRAINER_READY
);

    // Load states are numbered so that (state - StLoadW) is the phase index.
    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StLoadW = 4'd1,
        StLoadK = 4'd2,
        StLoadU = 4'd3,
        StLoadB = 4'd4,
        StLoadX = 4'd5,
        StLoadR = 4'd6,
        StLoadH = 4'd7,
        StRun   = 4'd8,
        StWait  = 4'd9,
        StDone  = 4'd10
    } state_t;

    typedef logic [DATA_SIZE-1:0]      word_t;
    typedef logic [6:0][DATA_SIZE-1:0] cnt_t;

    function automatic cnt_t phase_counts(input word_t x, input word_t w, input word_t l,
                                          input word_t r);
        cnt_t c;
        c[0] = l * x;
        c[1] = l * w;
        c[2] = l * l;
        c[3] = l;
        c[4] = x;
        c[5] = r * w;
        c[6] = l;
        return c;
    endfunction

    // First phase at or after 'from' with a nonzero word count, else RUN.
    function automatic state_t next_phase(input int from, input cnt_t c);
        state_t s;
        s = StRun;
        for (int i = 6; i >= 0; i--) begin
            if (i >= from && c[i] != '0) s = state_t'(4'(i + 1));
        end
        return s;
    endfunction

    state_t     state_q, state_d;
    word_t      size_x_q, size_w_q, size_l_q, size_r_q;
    word_t      word_cnt_q, word_cnt_d;
    logic [6:0] en_q;
    word_t      data_q;
    cnt_t       cnt_lat;
    logic [2:0] phase;
    logic       accept;

    assign cnt_lat       = phase_counts(size_x_q, size_w_q, size_l_q, size_r_q);
    assign phase         = 3'(state_q - StLoadW);
    assign DATA_IN_READY = (state_q >= StLoadW) && (state_q <= StLoadH);
    assign accept        = DATA_IN_READY && DATA_IN_VALID;
    assign BUSY          = (state_q != StIdle);
    assign READY         = (state_q == StDone);
    assign TRAINER_START = (state_q == StRun);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            StIdle: begin
                if (START) begin
                    word_cnt_d = '0;
                    state_d    = next_phase(0, phase_counts(SIZE_X_IN, SIZE_W_IN, SIZE_L_IN,
                                                            SIZE_R_IN));
                end
            end
            StLoadW, StLoadK, StLoadU, StLoadB, StLoadX, StLoadR, StLoadH: begin
                if (accept) begin
                    if (word_cnt_q == cnt_lat[phase] - 1'b1) begin
                        word_cnt_d = '0;
                        state_d    = next_phase(int'(phase) + 1, cnt_lat);
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            StRun:   state_d = StWait;
            StWait:  if (TRAINER_READY) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            size_x_q   <= '0;
            size_w_q   <= '0;
            size_l_q   <= '0;
            size_r_q   <= '0;
            en_q       <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            if (state_q == StIdle && START) begin
                size_x_q <= SIZE_X_IN;
                size_w_q <= SIZE_W_IN;
                size_l_q <= SIZE_L_IN;
                size_r_q <= SIZE_R_IN;
            end
            en_q <= accept ? (7'd1 << phase) : 7'd0;
            if (accept) data_q <= DATA_IN;
        end
    end

    assign TRAINER_DATA     = data_q;
    assign TRAINER_W_ENABLE = en_q[0];
    assign TRAINER_K_ENABLE = en_q[1];
    assign TRAINER_U_ENABLE = en_q[2];
    assign TRAINER_B_ENABLE = en_q[3];
    assign TRAINER_X_ENABLE = en_q[4];
    assign TRAINER_R_ENABLE = en_q[5];
    assign TRAINER_H_ENABLE = en_q[6];

endmodule

// File: tb/tb_model_trainer_lstm_loader.sv
// Directed-plus-random bench: a word queue built from the phase-size rules predicts every
// trainer strobe, its data, and the RUN/WAIT/DONE handshake.
module tb_model_trainer_lstm_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        READY;
    logic        BUSY;
    logic [63:0] SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN;
    logic [63:0] DATA_IN;
    logic        DATA_IN_VALID;
    logic        DATA_IN_READY;
    logic [63:0] TRAINER_DATA;
    logic        w_en, k_en, u_en, b_en, x_en, r_en, h_en;
    logic        TRAINER_START;
    logic        TRAINER_READY;

    int total = 0;
    int bad   = 0;

    model_trainer_lstm_loader #(.DATA_SIZE(64)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .START            (START),
        .READY            (READY),
        .BUSY             (BUSY),
        .SIZE_X_IN        (SIZE_X_IN),
        .SIZE_W_IN        (SIZE_W_IN),
        .SIZE_L_IN        (SIZE_L_IN),
        .SIZE_R_IN        (SIZE_R_IN),
        .DATA_IN          (DATA_IN),
        .DATA_IN_VALID    (DATA_IN_VALID),
        .DATA_IN_READY    (DATA_IN_READY),
        .TRAINER_DATA     (TRAINER_DATA),
        .TRAINER_W_ENABLE (w_en),
        .TRAINER_K_ENABLE (k_en),
        .TRAINER_U_ENABLE (u_en),
        .TRAINER_B_ENABLE (b_en),
        .TRAINER_X_ENABLE (x_en),
        .TRAINER_R_ENABLE (r_en),
        .TRAINER_H_ENABLE (h_en),
        .TRAINER_START    (TRAINER_START),
        .TRAINER_READY    (TRAINER_READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] strobes();
        return {h_en, r_en, x_en, b_en, u_en, k_en, w_en};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, READY, 1'b0);
        chk({tag, "_busy"}, BUSY, 1'b0);
        chk({tag, "_in_ready"}, DATA_IN_READY, 1'b0);
        chk({tag, "_tstart"}, TRAINER_START, 1'b0);
        chk({tag, "_strobes"}, strobes(), 7'd0);
        chk({tag, "_tdata"}, TRAINER_DATA, 64'd0);
    endtask

    // mode: 0 valid always, 1 valid every other cycle, 2 random valid.
    // rst_after > 0 aborts the load with a reset right after that many accepted words.
    task automatic do_seq(input int x, input int w, input int l, input int r, input int mode,
                          input int wait_cycles, input bit start_in_wait, input int rst_after);
        int          cnt[7];
        int          ph_q[$];
        logic [63:0] dat_q[$];
        logic [63:0] last_data;
        int          idx, cyc, budget, strobe_total;
        bit          v;

        cnt = '{l * x, l * w, l * l, l, x, r * w, l};
        for (int p = 0; p < 7; p++) begin
            for (int k = 0; k < cnt[p]; k++) begin
                ph_q.push_back(p);
                dat_q.push_back({$urandom, $urandom});
            end
        end

        SIZE_X_IN = 64'(x);
        SIZE_W_IN = 64'(w);
        SIZE_L_IN = 64'(l);
        SIZE_R_IN = 64'(r);
        START     = 1'b1;
        tick();
        START     = 1'b0;
        // Latched sizes must ignore later input changes.
        SIZE_X_IN = 64'($urandom_range(1, 7));
        SIZE_W_IN = 64'($urandom_range(1, 7));
        SIZE_L_IN = 64'($urandom_range(1, 7));
        SIZE_R_IN = 64'($urandom_range(1, 7));
        chk("busy_after_start", BUSY, 1'b1);

        idx          = 0;
        cyc          = 0;
        strobe_total = 0;
        budget       = 4 * ph_q.size() + 10;
        last_data    = TRAINER_DATA;
        while (idx < ph_q.size() && cyc < budget) begin
            chk("in_ready_load", DATA_IN_READY, 1'b1);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            DATA_IN_VALID = v;
            DATA_IN       = v ? dat_q[idx] : {$urandom, $urandom};
            tick();
            cyc++;
            strobe_total += $countones(strobes());
            if (v) begin
                chk("strobe_phase", {57'd0, strobes()}, 64'(7'd1 << ph_q[idx]));
                chk("strobe_data", TRAINER_DATA, dat_q[idx]);
                last_data = dat_q[idx];
                idx++;
                if (idx == rst_after) begin
                    DATA_IN_VALID = 1'b0;
                    #1 RST = 1'b1;
                    #1 chk_all_zero("reset_mid");
                    #1 RST = 1'b0;
                    tick();
                    chk_all_zero("after_reset");
                    return;
                end
            end else begin
                chk("no_strobe", strobes(), 7'd0);
                chk("data_hold", TRAINER_DATA, last_data);
            end
        end
        DATA_IN_VALID = 1'b0;
        chk("load_within_budget", 64'(idx), 64'(ph_q.size()));
        chk("strobe_count", 64'(strobe_total), 64'(ph_q.size()));

        chk("run_tstart", TRAINER_START, 1'b1);
        chk("run_in_ready", DATA_IN_READY, 1'b0);
        tick();
        chk("wait_tstart", TRAINER_START, 1'b0);
        chk("wait_busy", BUSY, 1'b1);
        chk("wait_strobes", strobes(), 7'd0);
        for (int k = 0; k < wait_cycles; k++) begin
            START = start_in_wait;
            tick();
            START = 1'b0;
            chk("wait_ready_low", READY, 1'b0);
            chk("wait_no_restart", TRAINER_START, 1'b0);
            chk("wait_no_load", DATA_IN_READY, 1'b0);
        end
        TRAINER_READY = 1'b1;
        tick();
        TRAINER_READY = 1'b0;
        chk("done_ready", READY, 1'b1);
        chk("done_busy", BUSY, 1'b1);
        tick();
        chk("idle_ready", READY, 1'b0);
        chk("idle_busy", BUSY, 1'b0);
        tick();
        chk("idle_ready_stays_low", READY, 1'b0);
    endtask

    initial begin
        RST           = 1'b1;
        START         = 1'b0;
        SIZE_X_IN     = '0;
        SIZE_W_IN     = '0;
        SIZE_L_IN     = '0;
        SIZE_R_IN     = '0;
        DATA_IN       = '0;
        DATA_IN_VALID = 1'b0;
        TRAINER_READY = 1'b0;
        #12;
        chk_all_zero("reset");
        RST = 1'b0;
        tick();
        chk_all_zero("idle");

        do_seq(2, 1, 1, 1, 0, 2, 1'b0, 0);   // nine-word reference sequence
        do_seq(2, 1, 1, 1, 1, 2, 1'b0, 0);   // valid every other cycle
        do_seq(3, 2, 2, 0, 0, 1, 1'b0, 0);   // R phase skipped
        do_seq(0, 0, 0, 0, 0, 1, 1'b0, 0);   // straight to RUN
        do_seq(2, 1, 1, 1, 0, 20, 1'b1, 0);  // long wait with START pokes
        do_seq(2, 1, 1, 1, 0, 2, 1'b0, 3);   // reset after third word
        do_seq(2, 1, 1, 1, 0, 2, 1'b0, 0);   // full reload from word 0
        for (int t = 0; t < 4; t++) begin
            do_seq($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2, $urandom_range(0, 5), 1'b1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
